// File: rtl/ramp_pkg.sv
// ramp_pkg: shared encodings for the DDS ramp envelope handshake.
//  - Ramper state encodings as reported on ramp_state (signal_ramper uses the same values).
//  - Sequencer FSM state type and two decode helpers used for the registered outputs.
package ramp_pkg;

    localparam logic [1:0] RAMP_UP   = 2'b10;
    localparam logic [1:0] NORMAL    = 2'b00;
    localparam logic [1:0] RAMP_DOWN = 2'b11;
    localparam logic [1:0] DONE      = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RAMP_UP,
        S_HOLD,
        S_RAMP_DOWN,
        S_DONE
    } seq_state_t;

    // Sequence in progress: everything from arming up to the end of ramp-down.
    function automatic logic seq_busy(input seq_state_t s);
        return (s == S_ARM) || (s == S_RAMP_UP) || (s == S_HOLD) || (s == S_RAMP_DOWN);
    endfunction

    // Ramper is out of restart once the wrap-aligned release has happened. It stays
    // released through DONE so the ramper keeps holding its zero output.
    function automatic logic ramper_released(input seq_state_t s);
        return (s == S_RAMP_UP) || (s == S_HOLD) || (s == S_RAMP_DOWN) || (s == S_DONE);
    endfunction

endpackage

// File: rtl/phase_wrap_detect.sv
// phase_wrap_detect: flags a DDS phase wrap.
//  Ports:
//   clk, aresetn   clock, asynchronous active-low reset
//   i_tdata        DDS phase word
//   i_tvalid       phase sample valid; invalid samples are neither compared nor stored
//   o_wrap         1 in the cycle whose valid sample's MSBs are below the previous valid sample's
module phase_wrap_detect #(
    parameter int PHASE_WIDTH = 48,
    parameter int PHASE_BITS  = 13
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [PHASE_WIDTH-1:0] i_tdata,
    input  logic                   i_tvalid,
    output logic                   o_wrap
);

    logic [PHASE_BITS-1:0] w_ph;
    logic [PHASE_BITS-1:0] r_ph;
    logic                  r_ph_vld;
    logic                  w_unused_lsbs;

    assign w_ph          = i_tdata[PHASE_WIDTH-1 -: PHASE_BITS];
    assign w_unused_lsbs = ^i_tdata[PHASE_WIDTH-PHASE_BITS-1:0];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_ph     <= '0;
            r_ph_vld <= 1'b0;
        end else if (i_tvalid) begin
            r_ph     <= w_ph;
            r_ph_vld <= 1'b1;
        end
    end

    // No reference sample yet after reset -> no wrap can be claimed.
    assign o_wrap = i_tvalid && r_ph_vld && (w_ph < r_ph);

endmodule

// File: rtl/ramp_sequencer.sv
// ramp_sequencer: initiator for the DDS ramp envelope handshake.
//  Releases the ramper on a phase wrap, holds full scale for cfg_hold_periods wraps (or until
//  sw_stop), requests ramp-down and follows the ramper to DONE. Stalls raise a sticky error.
//  Ports:
//   clk, aresetn                      clock, asynchronous active-low reset
//   s_axis_tdata_phase/_tvalid_phase  DDS phase stream
//   cfg_enable_ramping, cfg_hold_periods  latched on an accepted sw_start
//   sw_start, sw_stop                 1-cycle software pulses
//   ramp_state                        state reported by the ramper
//   ramper_resetn, enable_ramping, start_ramp_down  controls to the ramper
//   busy, done, error, periods_elapsed              status to the PS
module ramp_sequencer #(
    parameter int PHASE_WIDTH   = 48,
    parameter int PHASE_BITS    = 13,
    parameter int CNT_WIDTH     = 32,
    parameter int TIMEOUT_WRAPS = 3
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [PHASE_WIDTH-1:0] s_axis_tdata_phase,
    input  logic                   s_axis_tvalid_phase,
    input  logic                   cfg_enable_ramping,
    input  logic [CNT_WIDTH-1:0]   cfg_hold_periods,
    input  logic                   sw_start,
    input  logic                   sw_stop,
    input  logic [1:0]             ramp_state,
    output logic                   ramper_resetn,
    output logic                   enable_ramping,
    output logic                   start_ramp_down,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [CNT_WIDTH-1:0]   periods_elapsed
);
    import ramp_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT_WRAPS + 1);

    seq_state_t           r_state, w_state_nxt;
    logic                 r_resetn, w_resetn_nxt;
    logic                 r_enable, w_enable_nxt;
    logic                 r_srd, w_srd_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_error, w_error_nxt;
    logic [CNT_WIDTH-1:0] r_periods, w_periods_nxt;
    logic [CNT_WIDTH-1:0] r_hold, w_hold_nxt;
    logic                 r_stop_pend, w_stop_pend_nxt;
    logic [WD_W-1:0]      r_wd, w_wd_nxt;
    logic                 w_wrap;
    logic                 w_wd_hit;
    logic                 w_hold_hit;

    phase_wrap_detect #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .PHASE_BITS  (PHASE_BITS)
    ) u_wrap (
        .clk      (clk),
        .aresetn  (aresetn),
        .i_tdata  (s_axis_tdata_phase),
        .i_tvalid (s_axis_tvalid_phase),
        .o_wrap   (w_wrap)
    );

    // This wrap would be the TIMEOUT_WRAPS-th one without the expected ramper progress.
    assign w_wd_hit   = w_wrap && (r_wd == WD_W'(TIMEOUT_WRAPS - 1));
    // This wrap brings periods_elapsed up to a non-zero hold count.
    assign w_hold_hit = w_wrap && (r_hold != '0) && ((r_periods + CNT_WIDTH'(1)) == r_hold);

    always_comb begin
        w_state_nxt     = r_state;
        w_enable_nxt    = r_enable;
        w_srd_nxt       = r_srd;
        w_done_nxt      = r_done;
        w_error_nxt     = r_error;
        w_periods_nxt   = r_periods;
        w_hold_nxt      = r_hold;
        w_stop_pend_nxt = r_stop_pend;
        w_wd_nxt        = r_wd;
        if (w_wrap && ((r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN)))
            w_wd_nxt = r_wd + WD_W'(1);

        case (r_state)
            S_IDLE: begin
                if (sw_start && !sw_stop) begin
                    w_enable_nxt    = cfg_enable_ramping;
                    w_hold_nxt      = cfg_hold_periods;
                    w_done_nxt      = 1'b0;
                    w_error_nxt     = 1'b0;
                    w_periods_nxt   = '0;
                    w_stop_pend_nxt = 1'b0;
                    w_state_nxt     = S_ARM;
                end
            end
            S_ARM: begin
                if (sw_stop) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_wrap) begin
                    w_wd_nxt    = '0;
                    w_state_nxt = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                // A stop here cannot interrupt the ramp-up; it is replayed on reaching HOLD.
                if (sw_stop)
                    w_stop_pend_nxt = 1'b1;
                if (ramp_state == DONE) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (ramp_state == NORMAL) begin
                    w_state_nxt = S_HOLD;
                    if (r_stop_pend || sw_stop)
                        w_srd_nxt = 1'b1;
                end else if (w_wd_hit) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (w_wrap && (r_periods != '1))
                    w_periods_nxt = r_periods + CNT_WIDTH'(1);
                if (ramp_state == DONE) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_stop_pend || sw_stop || w_hold_hit) begin
                    w_srd_nxt   = 1'b1;
                    w_wd_nxt    = '0;
                    w_state_nxt = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                if (ramp_state == RAMP_DOWN)
                    w_srd_nxt = 1'b0;
                if (ramp_state == DONE) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_wd_hit) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE)) begin
            w_srd_nxt       = 1'b0;
            w_stop_pend_nxt = 1'b0;
        end
        w_resetn_nxt = ramper_released(w_state_nxt);
        w_busy_nxt   = seq_busy(w_state_nxt);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_resetn    <= 1'b0;
            r_enable    <= 1'b0;
            r_srd       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_periods   <= '0;
            r_hold      <= '0;
            r_stop_pend <= 1'b0;
            r_wd        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_resetn    <= w_resetn_nxt;
            r_enable    <= w_enable_nxt;
            r_srd       <= w_srd_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_periods   <= w_periods_nxt;
            r_hold      <= w_hold_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_wd        <= w_wd_nxt;
        end
    end

    assign ramper_resetn   = r_resetn;
    assign enable_ramping  = r_enable;
    assign start_ramp_down = r_srd;
    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign periods_elapsed = r_periods;

endmodule

// File: tb/tb_ramp_sequencer.sv
// Bench for ramp_sequencer: phase generator (16 cycles per DDS period), behavioural ramper,
// expected-event queue filled by the stimulus and drained by an edge monitor.
module tb_ramp_sequencer;
    import ramp_pkg::*;

    localparam int PW = 48;
    localparam int PB = 13;
    localparam int CW = 32;
    localparam logic [PW-1:0] STEP = 48'h1000_0000_0000;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [PW-1:0] tdata = '0;
    logic          tvalid = 1'b0;
    logic          cfg_en = 1'b0;
    logic [CW-1:0] cfg_hold = '0;
    logic          sw_start = 1'b0;
    logic          sw_stop = 1'b0;
    logic [1:0]    ramp_state = RAMP_UP;
    logic          ramper_resetn, enable_ramping, start_ramp_down, busy, done, error;
    logic [CW-1:0] periods_elapsed;

    always #5 clk = ~clk;

    ramp_sequencer #(.PHASE_WIDTH(PW), .PHASE_BITS(PB), .CNT_WIDTH(CW), .TIMEOUT_WRAPS(3)) dut (
        .clk                 (clk),
        .aresetn             (aresetn),
        .s_axis_tdata_phase  (tdata),
        .s_axis_tvalid_phase (tvalid),
        .cfg_enable_ramping  (cfg_en),
        .cfg_hold_periods    (cfg_hold),
        .sw_start            (sw_start),
        .sw_stop             (sw_stop),
        .ramp_state          (ramp_state),
        .ramper_resetn       (ramper_resetn),
        .enable_ramping      (enable_ramping),
        .start_ramp_down     (start_ramp_down),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .periods_elapsed     (periods_elapsed)
    );

    typedef enum {EV_RSTN, EV_SRD, EV_END} ev_k;
    typedef enum {R_NONE, R_WRAP, R_STOP, R_NORMAL} ref_k;
    typedef struct {
        ev_k  kind;
        ref_k rf;
        logic done;
        logic err;
        int   periods;
        int   wraps;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wrap_cnt = 0;
    int last_wrap = -100;
    int last_stop = -100;
    int normal_cyc = -100;
    int base_wraps = 0;
    int hold_base = 0;
    bit gap = 1'b0;
    bit frozen = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic push(input ev_k k, input ref_k r, input logic d, input logic e,
                        input int p, input int w);
        exp_t x;
        x.kind = k; x.rf = r; x.done = d; x.err = e; x.periods = p; x.wraps = w;
        q.push_back(x);
    endtask

    // Phase generator plus an independent wrap model on the same valid-gated rule.
    logic [PW-1:0] phase = '0;
    logic [PB-1:0] tb_ph, tb_prev;
    bit            tb_prev_vld = 1'b0;
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (!aresetn) tb_prev_vld = 1'b0;
        phase  = phase + STEP;
        tdata  = phase;
        tvalid = !gap;
        if (tvalid) begin
            tb_ph = phase[PW-1 -: PB];
            if (tb_prev_vld && (tb_ph < tb_prev)) begin
                wrap_cnt++;
                last_wrap = cyc;
            end
            tb_prev     = tb_ph;
            tb_prev_vld = 1'b1;
        end
    end

    // Ramper model: 6 cycles ramp-up, waits for start_ramp_down, 6 cycles ramp-down, DONE.
    int rcnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!ramper_resetn) begin
            ramp_state = RAMP_UP;
            rcnt = 0;
        end else if (!frozen) begin
            case (ramp_state)
                RAMP_UP: begin
                    rcnt++;
                    if (rcnt == 6) begin ramp_state = NORMAL; normal_cyc = cyc; end
                end
                NORMAL: if (start_ramp_down) begin ramp_state = RAMP_DOWN; rcnt = 0; end
                RAMP_DOWN: begin
                    rcnt++;
                    if (rcnt == 6) ramp_state = DONE;
                end
                default: ;
            endcase
        end
    end

    task automatic handle(input ev_k k);
        exp_t e;
        int rc;
        if (k == EV_RSTN) base_wraps = wrap_cnt;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s, required no event", k.name());
            return;
        end
        e = q.pop_front();
        if (e.kind != k) begin
            errors++;
            $display("FAIL event_order: got %s, required %s", k.name(), e.kind.name());
            return;
        end
        if (e.rf != R_NONE) begin
            rc = (e.rf == R_WRAP) ? last_wrap : (e.rf == R_STOP) ? last_stop : normal_cyc;
            chk({k.name(), "_latency"}, cyc - rc, 1);
        end
        if (k == EV_SRD) chk("srd_periods", periods_elapsed, e.periods);
        if (k == EV_END) begin
            chk("end_done", done, e.done);
            chk("end_error", error, e.err);
            chk("end_periods", periods_elapsed, e.periods);
            if (e.wraps >= 0) chk("end_wraps", wrap_cnt - base_wraps, e.wraps);
        end
    endtask

    logic p_rstn = 1'b0, p_srd = 1'b0, p_busy = 1'b0;
    initial forever begin
        @(negedge clk);
        if (ramper_resetn && !p_rstn) handle(EV_RSTN);
        if (start_ramp_down && !p_srd) handle(EV_SRD);
        if (!busy && p_busy) handle(EV_END);
        p_rstn = ramper_resetn;
        p_srd  = start_ramp_down;
        p_busy = busy;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse(input bit st, input bit sp);
        sw_start = st;
        sw_stop  = sp;
        if (sp) last_stop = cyc;
        tick(1);
        sw_start = 1'b0;
        sw_stop  = 1'b0;
    endtask

    function automatic bit cond(input int what, input int arg);
        case (what)
            0: return ramp_state == NORMAL;
            1: return ramper_resetn == 1'b1;
            2: return (cyc - last_wrap) == arg;
            3: return q.size() == 0;
            default: return (wrap_cnt - hold_base) >= arg;
        endcase
    endfunction

    task automatic wait_until(input int what, input int arg, input int budget, input string nm);
        int n = 0;
        while (!cond(what, arg) && n < budget) begin tick(1); n++; end
        if (!cond(what, arg)) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout after %0d cycles, required condition reached", nm, budget);
            if (what == 3) q.delete();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ramper_resetn"}, ramper_resetn, 0);
        chk({tag, "_enable"}, enable_ramping, 0);
        chk({tag, "_srd"}, start_ramp_down, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_periods"}, periods_elapsed, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        tick(3);
        chk_reset("reset");
        aresetn = 1'b1;
        tick(20);

        // 1: hold=4, start mid-period; an ignored start while busy must not re-latch cfg.
        cfg_hold = 4; cfg_en = 1'b1;
        wait_until(2, 7, 40, "t1_midperiod");
        push(EV_RSTN, R_WRAP, 0, 0, 0, -1);
        push(EV_SRD, R_WRAP, 0, 0, 4, -1);
        push(EV_END, R_NONE, 1, 0, 4, -1);
        pulse(1, 0);
        chk("t1_busy", busy, 1);
        chk("t1_done_clr", done, 0);
        chk("t1_enable", enable_ramping, 1);
        tick(28);
        cfg_hold = 2; cfg_en = 1'b0;
        pulse(1, 0);
        cfg_hold = 4; cfg_en = 1'b1;
        chk("t1_enable_kept", enable_ramping, 1);
        wait_until(3, 0, 300, "t1_sequence");
        tick(3);
        chk("t1_done_sticky", done, 1);
        chk("t1_rstn_idle", ramper_resetn, 0);
        chk("t1_periods_kept", periods_elapsed, 4);

        // 2: hold=0, enable=0, tvalid gap in HOLD, sw_stop after 10 wraps.
        cfg_hold = 0; cfg_en = 1'b0;
        push(EV_RSTN, R_WRAP, 0, 0, 0, -1);
        push(EV_SRD, R_STOP, 0, 0, 10, -1);
        push(EV_END, R_NONE, 1, 0, 10, -1);
        pulse(1, 0);
        chk("t2_enable", enable_ramping, 0);
        wait_until(0, 0, 60, "t2_normal");
        hold_base = wrap_cnt;
        wait_until(4, 3, 80, "t2_wraps3");
        tick(2);
        gap = 1'b1;
        tick(40);
        gap = 1'b0;
        wait_until(4, 10, 200, "t2_wraps10");
        tick(3);
        pulse(0, 1);
        wait_until(3, 0, 100, "t2_sequence");
        chk("t2_error", error, 0);

        // 3: sw_stop during RAMP_UP -> ramp-down on entering HOLD.
        cfg_hold = 4; cfg_en = 1'b1;
        push(EV_RSTN, R_WRAP, 0, 0, 0, -1);
        push(EV_SRD, R_NORMAL, 0, 0, 0, -1);
        push(EV_END, R_NONE, 1, 0, 0, -1);
        pulse(1, 0);
        wait_until(1, 0, 40, "t3_release");
        tick(2);
        pulse(0, 1);
        wait_until(3, 0, 100, "t3_sequence");

        // 4: ramper frozen in RAMP_UP -> error after 3 wraps.
        frozen = 1'b1;
        push(EV_RSTN, R_WRAP, 0, 0, 0, -1);
        push(EV_END, R_WRAP, 0, 1, 0, 3);
        pulse(1, 0);
        wait_until(3, 0, 200, "t4_sequence");
        tick(2);
        chk("t4_busy", busy, 0);
        chk("t4_error", error, 1);
        chk("t4_rstn", ramper_resetn, 0);
        frozen = 1'b0;

        // 5: start+stop together is refused; error stays sticky.
        pulse(1, 1);
        tick(3);
        chk("t5_busy", busy, 0);
        chk("t5_error_sticky", error, 1);
        chk("t5_rstn", ramper_resetn, 0);

        // 5b: stop while armed -> IDLE with done, error cleared by the start.
        wait_until(2, 1, 40, "t5b_align");
        push(EV_END, R_STOP, 1, 0, 0, -1);
        pulse(1, 0);
        chk("t5b_error_clr", error, 0);
        chk("t5b_busy", busy, 1);
        tick(1);
        pulse(0, 1);
        wait_until(3, 0, 20, "t5b_sequence");
        chk("t5b_rstn", ramper_resetn, 0);

        // 6: asynchronous reset in HOLD.
        cfg_hold = 0;
        push(EV_RSTN, R_WRAP, 0, 0, 0, -1);
        push(EV_END, R_NONE, 0, 0, 0, -1);
        pulse(1, 0);
        wait_until(0, 0, 60, "t6_normal");
        tick(20);
        chk("t6_in_hold", busy, 1);
        @(posedge clk);
        #3;
        aresetn = 1'b0;
        #1;
        chk_reset("t6");
        tick(3);
        aresetn = 1'b1;
        tick(2);
        wait_until(3, 0, 10, "t6_events");

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
